// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with misaligned split into two bus beats
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  mem_op,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t state;

  logic        is_store_q;
  logic [2:0]  width_q;
  logic [1:0]  off_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q;
  logic [31:0] lo_q;

  logic        req, illegal, legal;
  logic [3:0]  mask;
  logic [7:0]  be8_new;
  logic [63:0] wd64_new;
  logic [31:0] lo_sel, hi_sel, r, load_result;

  always_comb begin
    req     = valid_i & (mem_op[3] | mem_op[4]);
    illegal = req & ((mem_op[3] & mem_op[4]) |
                     (mem_op[2:0] == 3'b111) | (mem_op[2:0] == 3'b011) |
                     (mem_op[2:0] == 3'b110) | (mem_op[4] & mem_op[2]));
    legal   = req & ~illegal;
    case (mem_op[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    be8_new  = {4'b0000, mask} << addr_i[1:0];
    wd64_new = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
  end

  // Reassemble from the beat completing this cycle; hi stays 0 for single-beat accesses.
  always_comb begin
    lo_sel = (state == BEAT1) ? lo_q : bus_rdata;
    hi_sel = (state == BEAT1) ? bus_rdata : 32'b0;
    r      = 32'({hi_sel, lo_sel} >> {off_q, 3'b000});
    case (width_q)
      3'b000:  load_result = {{24{r[7]}}, r[7:0]};
      3'b001:  load_result = {{16{r[15]}}, r[15:0]};
      3'b100:  load_result = {24'b0, r[7:0]};
      3'b101:  load_result = {16'b0, r[15:0]};
      default: load_result = r;
    endcase
    if (is_store_q) load_result = 32'b0;
  end

  assign stall_o = ~rst & ((state == BEAT0) | (state == BEAT1) | ((state == IDLE) & legal));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'b0;
      bus_wdata  <= 32'b0;
      bus_be     <= 4'b0;
      rdata_o    <= 32'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      is_store_q <= 1'b0;
      width_q    <= 3'b0;
      off_q      <= 2'b0;
      be_hi_q    <= 4'b0;
      wd_hi_q    <= 32'b0;
      lo_q       <= 32'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          err_o <= illegal;
          if (legal) begin
            state      <= BEAT0;
            is_store_q <= mem_op[4];
            width_q    <= mem_op[2:0];
            off_q      <= addr_i[1:0];
            be_hi_q    <= be8_new[7:4];
            wd_hi_q    <= wd64_new[63:32];
            bus_req    <= 1'b1;
            bus_we     <= mem_op[4];
            bus_addr   <= {addr_i[31:2], 2'b00};
            bus_be     <= be8_new[3:0];
            bus_wdata  <= wd64_new[31:0];
          end
        end
        BEAT0: if (bus_ready) begin
          if (be_hi_q != 4'b0) begin
            state     <= BEAT1;
            bus_addr  <= bus_addr + 32'd4;
            bus_be    <= be_hi_q;
            bus_wdata <= wd_hi_q;
            lo_q      <= bus_rdata;
          end else begin
            state   <= DONE;
            bus_req <= 1'b0;
            done_o  <= 1'b1;
            rdata_o <= load_result;
          end
        end
        BEAT1: if (bus_ready) begin
          state   <= DONE;
          bus_req <= 1'b0;
          done_o  <= 1'b1;
          rdata_o <= load_result;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a wait-state bus responder
module tb_mem_access_unit;
  logic        clk = 0;
  logic        rst, valid_i, stall_o, done_o, err_o;
  logic [4:0]  mem_op;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op(mem_op), .addr_i(addr_i),
    .wdata_i(wdata_i), .stall_o(stall_o), .rdata_o(rdata_o), .done_o(done_o),
    .err_o(err_o), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_res[$];
  logic [31:0] mem [logic [31:0]];
  int          total = 0, bad = 0;
  int          wait_cfg = 0, wcnt = 0;
  logic [31:0] hold_addr, hold_wd;
  logic [3:0]  hold_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  function automatic logic [3:0] size_mask(input logic [4:0] op);
    case (op[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic int beats_of(input logic [4:0] op, input logic [31:0] a);
    logic [7:0] b8;
    b8 = {4'b0, size_mask(op)} << a[1:0];
    return (b8[7:4] != 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] a);
    logic [31:0] base, lo, hi, r;
    logic [63:0] w;
    base = {a[31:2], 2'b00};
    lo = rd_mem(base);
    hi = (beats_of(op, a) == 2) ? rd_mem(base + 32'd4) : 32'b0;
    w = {hi, lo} >> (8 * a[1:0]);
    r = w[31:0];
    if (op[4]) return 32'b0;
    case (op[2:0])
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'b0, r[7:0]};
      3'b101:  return {16'b0, r[15:0]};
      default: return r;
    endcase
  endfunction

  task automatic push_beats(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0]  b8;
    logic [63:0] w64;
    logic [31:0] base;
    beat_t       bt;
    b8 = {4'b0, size_mask(op)} << a[1:0];
    w64 = {32'b0, wd} << (8 * a[1:0]);
    base = {a[31:2], 2'b00};
    bt.addr = base; bt.be = b8[3:0]; bt.we = op[4]; bt.wd = w64[31:0];
    exp_beats.push_back(bt);
    if (b8[7:4] != 0) begin
      bt.addr = base + 32'd4; bt.be = b8[7:4]; bt.wd = w64[63:32];
      exp_beats.push_back(bt);
    end
  endtask

  // Bus responder: decides ready at negedge; ready is also 1 when idle to show it is ignored.
  always @(negedge clk) begin
    if (bus_req && !rst) begin
      chk("be_nonzero", {31'b0, bus_be != 4'b0}, 32'd1);
      if (wcnt == 0) begin
        hold_addr = bus_addr; hold_be = bus_be; hold_wd = bus_wdata;
      end else begin
        chk("hold_addr", bus_addr, hold_addr);
        chk("hold_be", {28'b0, bus_be}, {28'b0, hold_be});
        chk("hold_wdata", bus_wdata, hold_wd);
      end
      if (wcnt < wait_cfg) begin
        bus_ready = 1'b0;
        wcnt++;
      end else begin
        bus_ready = 1'b1;
        bus_rdata = rd_mem(bus_addr);
        wcnt = 0;
        if (exp_beats.size() == 0) chk("beat_unexpected", bus_addr, 32'hFFFF_FFFF);
        else begin
          beat_t e;
          e = exp_beats.pop_front();
          chk("beat_addr", bus_addr, e.addr);
          chk("beat_be", {28'b0, bus_be}, {28'b0, e.be});
          chk("beat_we", {31'b0, bus_we}, {31'b0, e.we});
          if (e.we) chk("beat_wdata", bus_wdata, e.wd);
        end
      end
    end else begin
      bus_ready = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (done_o) begin
      if (exp_res.size() == 0) chk("done_unexpected", rdata_o, 32'hFFFF_FFFF);
      else chk("rdata", rdata_o, exp_res.pop_front());
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] exp_rd, input int exp_lat);
    int  lat;
    bit  got;
    wait_cfg = waits;
    push_beats(op, a, wd);
    exp_res.push_back(exp_rd);
    @(posedge clk); #1;
    valid_i = 1; mem_op = op; addr_i = a; wdata_i = wd;
    @(negedge clk);
    chk("stall_accept", {31'b0, stall_o}, 32'd1);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done_o) got = 1;
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("stall_done", {31'b0, stall_o}, 32'd0);
    valid_i = 0;
    @(posedge clk); #1;
    chk("done_pulse", {31'b0, done_o}, 32'd0);
  endtask

  task automatic run_illegal(input logic [4:0] op);
    @(posedge clk); #1;
    valid_i = 1; mem_op = op; addr_i = 32'h100; wdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("ill_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    valid_i = 0;
    chk("ill_err", {31'b0, err_o}, 32'd1);
    chk("ill_req", {31'b0, bus_req}, 32'd0);
    chk("ill_done", {31'b0, done_o}, 32'd0);
    @(posedge clk); #1;
    chk("ill_err_pulse", {31'b0, err_o}, 32'd0);
    chk("ill_req2", {31'b0, bus_req}, 32'd0);
  endtask

  initial begin
    logic [4:0]  ops [8];
    logic [4:0]  op;
    logic [31:0] a, wd;
    int          w, nb, n;
    bit          seen;
    ops = '{5'b01_000, 5'b01_001, 5'b01_010, 5'b01_100, 5'b01_101,
            5'b10_000, 5'b10_001, 5'b10_010};
    rst = 1; valid_i = 0; mem_op = 0; addr_i = 0; wdata_i = 0;
    bus_ready = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    chk("rst_done_err", {30'b0, done_o, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst = 0;

    mem[32'h100] = 32'h8000_00F0;
    run_op(5'b01_010, 32'h100, 32'h0, 0, 32'h8000_00F0, 2);
    mem[32'h200] = 32'h8012_3456;
    run_op(5'b01_000, 32'h203, 32'h0, 0, 32'hFFFF_FF80, 2);
    run_op(5'b01_100, 32'h203, 32'h0, 0, 32'h0000_0080, 2);
    run_op(5'b10_010, 32'h102, 32'hAABB_CCDD, 0, 32'h0, 3);
    mem[32'h0FC] = 32'h1234_5678;
    mem[32'h100] = 32'h1122_3385;
    run_op(5'b01_001, 32'h0FF, 32'h0, 2, 32'hFFFF_8512, 7);
    run_op(5'b01_010, 32'hFFFF_FFFE, 32'h0, 1, model_load(5'b01_010, 32'hFFFF_FFFE), 5);
    run_illegal(5'b11_010);
    run_illegal(5'b10_100);
    run_illegal(5'b01_111);

    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 7)];
      a = $urandom;
      wd = $urandom;
      w = $urandom_range(0, 2);
      nb = beats_of(op, a);
      run_op(op, a, wd, w, model_load(op, a), 1 + nb + nb * w);
    end

    // Reset while waiting in the second beat of a split load.
    wait_cfg = 3;
    push_beats(5'b01_001, 32'h0FF, 32'h0);
    @(posedge clk); #1;
    valid_i = 1; mem_op = 5'b01_001; addr_i = 32'h0FF; wdata_i = 0;
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (bus_req && bus_addr == 32'h100) seen = 1;
    end
    chk("reach_beat1", {31'b0, seen}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_req", {31'b0, bus_req}, 32'd0);
    chk("rst_mid_done", {31'b0, done_o}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall_o}, 32'd0);
    rst = 0; valid_i = 0;
    exp_beats.delete();
    @(posedge clk); #1;
    chk("post_rst_done", {31'b0, done_o}, 32'd0);
    run_op(5'b01_010, 32'h100, 32'h0, 0, 32'h1122_3385, 2);

    repeat (3) @(posedge clk);
    chk("beats_drained", exp_beats.size(), 32'd0);
    chk("results_drained", exp_res.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit at the MEM stage: consumes the 5-bit `mem_op` produced by the instruction decoder, together with the effective address and store data, and runs word-wide transactions on the data bus. It generates byte enables, splits misaligned accesses into two bus beats, reassembles and sign- or zero-extends load data, and stalls the pipeline until the access completes.

## Interface
Parameters:
- none; address and data widths are fixed at 32.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: MEM stage holds a valid instruction.
- `mem_op` in 5: decoder encoding:
  - [4] store enable; [3] load enable.
  - [2:0] width: 000 B, 001 H, 010 W, 100 BU, 101 HU, 111 none.
- `addr_i` in 32: effective byte address.
- `wdata_i` in 32: store data, right-aligned.
- `stall_o` out 1: hold the pipeline. Combinational.
- `rdata_o` out 32: extended load result; valid while `done_o`=1.
- `done_o` out 1: one-cycle completion pulse, for loads and stores.
- `err_o` out 1: one-cycle illegal-request pulse.
- `bus_req` out 1: bus request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, bits [1:0] = 0.
- `bus_wdata` out 32: lane-positioned write data.
- `bus_be` out 4: byte enables, bit n = byte lane n.
- `bus_ready` in 1: bus accepts or completes the beat.
- `bus_rdata` in 32: read data, valid in the cycle `bus_req & bus_ready`.

## Operation
- Request condition: `valid_i` & (`mem_op[3]` | `mem_op[4]`).
- Illegal request: both bits set; width 111, 011, 110; or a store with width 1xx.
  - Pulse `err_o` for 1 cycle.
  - No bus traffic; `done_o` stays 0.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE, on a legal request:
  - Latch op, width, `off = addr_i[1:0]`, `wdata_i`, `base = addr_i & ~3`.
  - Go to BEAT0.
- Size: B/BU 1 byte, H/HU 2 bytes, W 4 bytes; `mask` = 0001 / 0011 / 1111.
- Lane positioning:
  - `be8 = mask << off` (8-bit).
  - `wd64 = {32'b0, wdata} << (8*off)`.
  - Two beats are needed iff `be8[7:4] != 0`, i.e. off+size > 4.
- BEAT0:
  - Drive `bus_req`=1, `bus_addr=base`, `bus_be=be8[3:0]`, `bus_wdata=wd64[31:0]`, `bus_we`=store.
  - On `bus_ready`, capture `bus_rdata` into lo. Go to BEAT1 if two beats are needed, else DONE.
- BEAT1:
  - Drive `bus_addr=base+4` (wraps modulo 2^32), `bus_be=be8[7:4]`, `bus_wdata=wd64[63:32]`.
  - On `bus_ready`, capture hi and go to DONE.
- DONE:
  - `done_o`=1; go to IDLE.
  - For loads, `rdata_o` is computed from `r = ({hi,lo} >> 8*off)[31:0]`:
    - LB: sign-extend r[7:0]. LBU: zero-extend r[7:0].
    - LH: sign-extend r[15:0]. LHU: zero-extend r[15:0]. LW: r.
  - For stores, `rdata_o` = 0.
  - `hi` = 0 when only one beat was used.
- `stall_o` = (state is BEAT0 or BEAT1) | (state is IDLE & legal request). It is 0 in DONE, so the pipeline advances on the DONE cycle.
- A request present in the DONE cycle is not accepted. It is the same instruction and is retiring.

## Timing
- Reset values: state IDLE; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `rdata_o`, `done_o`, `err_o` all 0. `stall_o` is forced to 0 while `rst`=1.
- Bus outputs are registered and held stable while `bus_req`=1 and `bus_ready`=0.
- `bus_ready` while `bus_req`=0 is ignored. A beat completes only on a rising edge with `bus_req & bus_ready`.
- Between beats, `bus_req` stays 1; address and enables change on the edge that completes BEAT0.
- Latency, accept cycle at t:
  - Aligned access with zero wait: BEAT0 at t+1, `done_o` at t+2.
  - Split access: `done_o` at t+3.
  - Each wait cycle adds 1.
- Illegal request: `err_o` at t+1. `stall_o` stays 0 at t.
- Reset mid-transaction: abandon the access, go to IDLE, and drive `bus_req`=0 from the next cycle. There are no partial `done_o`/`err_o` pulses.
- `bus_be` is never 0 while `bus_req`=1.

## Test plan
- LW addr 0x100, bus_rdata 0x8000_00F0, ready tied 1 → one beat, be 1111, addr 0x100; `done_o` 2 cycles after accept; `rdata_o` 0x8000_00F0.
- LB addr 0x203, rdata 0x80xx_xxxx; then LBU at the same address → rdata_o 0xFFFF_FF80, then 0x0000_0080; be 1000 both times.
- SW addr 0x102, data 0xAABB_CCDD → beat 0x100 be 1100 wdata 0xCCDD_0000; beat 0x104 be 0011 wdata 0x0000_AABB; `done_o` at t+3.
- LH addr 0x0FF (off 3), lo 0x12xx_xxxx, hi 0xxxxx_xx85 → two beats, be 1000 / 0001, rdata_o 0xFFFF_8512; with 2 wait cycles per beat, done at t+7 and bus outputs stable while waiting.
- mem_op 11_010, then 10_100 → `err_o` pulses, no `bus_req`, `stall_o` stays 0.
- `rst` asserted in BEAT1 with ready low → next cycle `bus_req`=0, state IDLE, no `done_o`; a following LW completes normally.
